// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: FSM state encoding,
// access-size codes, the wait-latency bound and small decode helpers.
package data_mem_ctrl_pkg;

    // Largest supported LATENCY value and the width of the wait counter
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Byte select wins over half-word select; neither means a full word
    function automatic size_e decode_size(input logic mem_byte, input logic mem_half_word);
        size_e sz;
        if (mem_byte) begin
            sz = SZ_BYTE;
        end else if (mem_half_word) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

    // Half-words need an even address, words need a 4-byte aligned address
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] addr_lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-addressed big-endian storage with byte-lane steering for sub-word
// accesses. The byte array "mem" is left unreset so it can be preloaded
// hierarchically. A write landing on the same edge a read is sampled is
// forwarded to the read lanes so the read observes the newer data.
module data_mem_array
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned SIZE  = 16384,
    parameter int unsigned IDX_W = $clog2(SIZE)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [1:0]       wr_size,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    input  logic [1:0]       rd_size,
    input  logic             rd_sign,
    output logic [31:0]      rd_data
);

    logic [7:0]       mem [0:SIZE-1];

    logic [3:0]       wr_lane_en_s;
    logic [IDX_W-1:0] wr_lane_idx_s [4];
    logic [7:0]       wr_lane_dat_s [4];
    logic [IDX_W-1:0] rd_lane_idx_s [4];
    logic [7:0]       rd_lane_s     [4];

    // Steer store data onto byte lanes; lane 0 is the byte at the base address (MSB side)
    always_comb begin
        wr_lane_en_s = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            wr_lane_idx_s[b] = wr_addr + IDX_W'(b);
            wr_lane_dat_s[b] = 8'h00;
        end
        case (size_e'(wr_size))
            SZ_BYTE: begin
                wr_lane_en_s     = {3'b000, wr_en};
                wr_lane_dat_s[0] = wr_data[7:0];
            end
            SZ_HALF: begin
                wr_lane_en_s     = {2'b00, wr_en, wr_en};
                wr_lane_dat_s[0] = wr_data[15:8];
                wr_lane_dat_s[1] = wr_data[7:0];
            end
            SZ_WORD: begin
                wr_lane_en_s     = {4{wr_en}};
                wr_lane_dat_s[0] = wr_data[31:24];
                wr_lane_dat_s[1] = wr_data[23:16];
                wr_lane_dat_s[2] = wr_data[15:8];
                wr_lane_dat_s[3] = wr_data[7:0];
            end
            default: begin
                wr_lane_en_s = 4'b0000;
            end
        endcase
    end

    // Commit enabled byte lanes into the array
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_lane_en_s[b]) begin
                mem[wr_lane_idx_s[b]] <= wr_lane_dat_s[b];
            end
        end
    end

    // Fetch the four read lanes, forwarding any byte being written on this edge
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            rd_lane_idx_s[b] = rd_addr + IDX_W'(b);
            rd_lane_s[b]     = mem[rd_lane_idx_s[b]];
            for (int w = 0; w < 4; w++) begin
                if (wr_lane_en_s[w] && (wr_lane_idx_s[w] == rd_lane_idx_s[b])) begin
                    rd_lane_s[b] = wr_lane_dat_s[w];
                end else begin
                    rd_lane_s[b] = rd_lane_s[b];
                end
            end
        end
    end

    // Assemble the load result with zero- or sign-extension for sub-word sizes
    always_comb begin
        rd_data = 32'h0000_0000;
        case (size_e'(rd_size))
            SZ_BYTE: rd_data = rd_sign ? {{24{rd_lane_s[0][7]}}, rd_lane_s[0]}
                                       : {24'h00_0000, rd_lane_s[0]};
            SZ_HALF: rd_data = rd_sign ? {{16{rd_lane_s[0][7]}}, rd_lane_s[0], rd_lane_s[1]}
                                       : {16'h0000, rd_lane_s[0], rd_lane_s[1]};
            SZ_WORD: rd_data = {rd_lane_s[0], rd_lane_s[1], rd_lane_s[2], rd_lane_s[3]};
            default: rd_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: accepts one load/store at a time, waits LATENCY
// cycles, then pulses ready for one cycle with the load result.
// Optional feature macro: DATA_MEM_CTRL_STATS_EN enables saturating
// completed-load/store counters; without it rd_count/wr_count are tied to 0.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned SIZE    = 16384,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        write_enable,
    input  logic        mem_byte,
    input  logic        mem_half_word,
    input  logic        sign_extend,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        ready,
    output logic        misalign_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int unsigned IDX_W = $clog2(SIZE);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (LATENCY > 0) ? WAIT_CNT_W'(LATENCY - 1) : {WAIT_CNT_W{1'b0}};

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r;
    logic [WAIT_CNT_W-1:0]   wait_cnt_nxt_s;
    logic                    accept_s;

    logic [IDX_W-1:0]        addr_r;
    logic [31:0]             wdata_r;
    size_e                   size_r;
    logic                    we_r;
    logic                    sext_r;

    logic [IDX_W-1:0]        eff_addr_s;
    size_e                   eff_size_s;
    logic                    eff_we_s;
    logic                    eff_sext_s;
    logic                    eff_mis_s;
    logic                    enter_resp_s;
    logic                    commit_s;
    logic [31:0]             rd_data_s;

    logic                    busy_r;
    logic                    ready_r;
    logic                    misalign_err_r;
    logic [31:0]             data_out_r;

    // Address bits above the array size wrap silently and are intentionally dropped
    logic                    addr_hi_unused_s;
    assign addr_hi_unused_s = ^addr[31:IDX_W];

    // Next-state logic; a request is only taken in IDLE or in the RESP cycle
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        accept_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (req) begin
                    accept_s       = 1'b1;
                    wait_cnt_nxt_s = WAIT_LOAD;
                    state_nxt_s    = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == {WAIT_CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pick the request whose response starts next: latched in WAIT, live inputs otherwise (LATENCY=0)
    always_comb begin
        if (state_r == ST_WAIT) begin
            eff_addr_s = addr_r;
            eff_size_s = size_r;
            eff_we_s   = we_r;
            eff_sext_s = sext_r;
        end else begin
            eff_addr_s = addr[IDX_W-1:0];
            eff_size_s = decode_size(mem_byte, mem_half_word);
            eff_we_s   = write_enable;
            eff_sext_s = sign_extend;
        end
    end

    assign eff_mis_s    = is_misaligned(eff_size_s, eff_addr_s[1:0]);
    assign enter_resp_s = (state_nxt_s == ST_RESP);
    // Stores land at the edge closing RESP unless misaligned or reset is asserted
    assign commit_s     = (state_r == ST_RESP) && we_r && !misalign_err_r && reset;

    data_mem_array #(
        .SIZE  (SIZE),
        .IDX_W (IDX_W)
    ) u_array (
        .clock   (clock),
        .wr_en   (commit_s),
        .wr_addr (addr_r),
        .wr_size (size_r),
        .wr_data (wdata_r),
        .rd_addr (eff_addr_s),
        .rd_size (eff_size_s),
        .rd_sign (eff_sext_s),
        .rd_data (rd_data_s)
    );

    // FSM state, wait counter and handshake outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            wait_cnt_r     <= {WAIT_CNT_W{1'b0}};
            busy_r         <= 1'b0;
            ready_r        <= 1'b0;
            misalign_err_r <= 1'b0;
            data_out_r     <= 32'h0000_0000;
        end else begin
            state_r        <= state_nxt_s;
            wait_cnt_r     <= wait_cnt_nxt_s;
            busy_r         <= (state_nxt_s == ST_WAIT);
            ready_r        <= enter_resp_s;
            misalign_err_r <= enter_resp_s && eff_mis_s;
            if (enter_resp_s && eff_mis_s) begin
                data_out_r <= 32'h0000_0000;
            end else if (enter_resp_s && !eff_we_s) begin
                data_out_r <= rd_data_s;
            end
        end
    end

    // Capture the request fields on acceptance
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_r  <= {IDX_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            size_r  <= SZ_WORD;
            we_r    <= 1'b0;
            sext_r  <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= addr[IDX_W-1:0];
            wdata_r <= data_in;
            size_r  <= decode_size(mem_byte, mem_half_word);
            we_r    <= write_enable;
            sext_r  <= sign_extend;
        end
    end

    assign data_out     = data_out_r;
    assign busy         = busy_r;
    assign ready        = ready_r;
    assign misalign_err = misalign_err_r;

`ifdef DATA_MEM_CTRL_STATS_EN
    logic [31:0] rd_count_r;
    logic [31:0] wr_count_r;

    // Count completed aligned accesses at the end of the ready cycle, saturating
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_count_r <= 32'h0000_0000;
            wr_count_r <= 32'h0000_0000;
        end else if (ready_r && !misalign_err_r) begin
            if (we_r) begin
                if (wr_count_r != 32'hFFFF_FFFF) begin
                    wr_count_r <= wr_count_r + 32'd1;
                end
            end else begin
                if (rd_count_r != 32'hFFFF_FFFF) begin
                    rd_count_r <= rd_count_r + 32'd1;
                end
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`else
    assign rd_count = 32'h0000_0000;
    assign wr_count = 32'h0000_0000;
`endif

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 16384, byte capacity of the array; power of two, at least 4.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between acceptance and response; range 0..15.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port req, input, 1, request valid.
REQ-006 SHALL have port write_enable, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have ports mem_byte and mem_half_word, input, 1 each, access size; both 0 = word, mem_byte takes priority.
REQ-008 SHALL have port sign_extend, input, 1, sign-extend sub-word loads.
REQ-009 SHALL have ports addr and data_in, input, 32 each, byte address and store data (stores use low-order bits for sub-word accesses).
REQ-010 SHALL have ports data_out, output, 32, load result; busy, output, 1, request in flight; ready, output, 1, one-cycle completion pulse; misalign_err, output, 1, qualified by ready.
REQ-011 SHALL have ports rd_count and wr_count, output, 32 each, completed-access counters.

Function
REQ-012 SHALL implement states IDLE, WAIT and RESP.
REQ-013 SHALL accept a request only in IDLE with req=1, latching addr, data_in, size, write_enable and sign_extend, then entering WAIT (or RESP when LATENCY=0); busy=1 from the next cycle.
REQ-014 SHALL leave WAIT after exactly LATENCY cycles, so ready is high in cycle k+1+LATENCY for acceptance at edge k.
REQ-015 SHALL hold ready high for exactly one cycle in RESP, then return to IDLE; busy=0 during RESP.
REQ-016 SHALL ignore req while busy; a new request can be accepted in the RESP cycle (back-to-back, one request per LATENCY+1 cycles).
REQ-017 SHALL store big-endian: the byte at addr holds word bits 31:24, and addr+3 holds bits 7:0.
REQ-018 SHALL index the array by addr modulo SIZE; upper address bits wrap silently.
REQ-019 SHALL commit stores at the edge that ends the RESP cycle; loads sample the array at the same point, and data_out is valid while ready=1.
REQ-020 SHALL zero-fill sub-word loads when sign_extend=0 and sign-extend them from bit 7 or bit 15 when sign_extend=1.
REQ-021 SHALL treat a half-word with addr[0]=1 or a word with addr[1:0]!=0 as misaligned: no array write, data_out=0, misalign_err=1 with ready, normal timing.
REQ-022 SHALL hold data_out at the last completed value outside ready.

Reset
REQ-023 SHALL, while reset=0 at a clock edge, set state=IDLE and busy=0, ready=0, misalign_err=0, data_out=0, rd_count=0, wr_count=0.
REQ-024 SHALL discard an in-flight request on reset: no write commits and no ready is issued; array contents are not cleared.

Configuration
REQ-025 SHALL, with DATA_MEM_CTRL_STATS_EN defined, increment rd_count or wr_count on each non-misaligned ready, saturating at 32'hFFFFFFFF.
REQ-026 SHALL, without DATA_MEM_CTRL_STATS_EN, drive rd_count=0 and wr_count=0 constantly and synthesise no counters.

Structure
REQ-027 SHALL place the state encoding, the size codes (BYTE/HALF/WORD) and the LATENCY bound constant in shared package data_mem_ctrl_pkg.
REQ-028 SHALL place byte-lane steering and the storage array in sub-module data_mem_array (byte array named mem, backdoor-loadable by hierarchical reference).

Verification
REQ-029 SHALL cover: LATENCY=2, store word 32'h11223344 to 0x10, then load word 0x10 -> ready 3 cycles after each acceptance, data_out=32'h11223344.
REQ-030 SHALL cover: load byte 0x13 with sign_extend=0 -> 32'h00000044; mem[0x12]=8'hF0, load byte 0x12 with sign_extend=1 -> 32'hFFFFFFF0.
REQ-031 SHALL cover: half-word store to 0x11 -> misalign_err=1, data_out=0, mem[0x10..0x13] unchanged.
REQ-032 SHALL cover: req held high for 5 cycles at LATENCY=2 -> exactly one acceptance before RESP, a second accepted in the RESP cycle.
REQ-033 SHALL cover: reset=0 asserted in the WAIT cycle of a store to 0x20 -> no ready pulse, mem[0x20..0x23] unchanged, all outputs 0.
REQ-034 SHALL cover: SIZE=16384, load from 0x00004010 -> returns contents of 0x10; with the STATS macro defined, rd_count increments by 1.
